// File: rtl/exec_div_seq.sv
// exec_div_seq: multi-cycle restoring DIV/IDIV sequencer, byte and word forms; define DIV_MINNEG_EN to accept the most-negative signed quotient
module exec_div_seq (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic [3:0]  iFunc,
  input  logic [31:0] iDividend,
  input  logic [15:0] iDivisor,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oQuot,
  output logic [15:0] oRem,
  output logic        oDivErr
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic word_q, word_d, sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, err_q, err_d;
  logic [15:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, quot_q, quot_d, rem_q, rem_d;
  logic [4:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, div_err_q, div_err_d;
  logic dvd_neg, dvs_neg, prep_err, ge, minneg_ok, fix_err;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag, mag_hi, mag_lo, q_signed, r_signed;
  logic [16:0] trial;
  logic unused_func;
  assign unused_func = ^iFunc[3:2];
  // hi_q holds the partial remainder and lo_q the dividend bits still to shift in, which fill with quotient bits;
  // byte dividends are left-aligned in lo_q so both widths consume from bit 15
  always_comb begin
    dvd_neg  = sgn_q & (word_q ? hi_q[15] : lo_q[15]);
    dvs_neg  = sgn_q & (word_q ? dvs_q[15] : dvs_q[7]);
    dvd_mag  = word_q ? (dvd_neg ? -{hi_q, lo_q} : {hi_q, lo_q}) : {16'h0, dvd_neg ? -lo_q : lo_q};
    dvs_mag  = word_q ? (dvs_neg ? -dvs_q : dvs_q) : {8'h0, dvs_neg ? -dvs_q[7:0] : dvs_q[7:0]};
    mag_hi   = word_q ? dvd_mag[31:16] : {8'h0, dvd_mag[15:8]};
    mag_lo   = word_q ? dvd_mag[15:0] : {dvd_mag[7:0], 8'h0};
    prep_err = mag_hi >= dvs_mag;
    trial    = {hi_q, lo_q[15]};
    ge       = trial >= {1'b0, dvs_q};
`ifdef DIV_MINNEG_EN
    minneg_ok = qneg_q & (lo_q == (word_q ? 16'h8000 : 16'h0080));
`else
    minneg_ok = 1'b0;
`endif
    fix_err  = err_q | (sgn_q & (lo_q > (word_q ? 16'h7FFF : 16'h007F)) & ~minneg_ok);
    q_signed = qneg_q ? -lo_q : lo_q;
    r_signed = rneg_q ? -hi_q : hi_q;
  end
  // sequencer: next state, datapath updates and registered outputs; PREP errors pass through FIX so every error reports two cycles after start
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    sgn_d = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    err_d = err_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    quot_d = quot_q;
    rem_d = rem_q;
    div_err_d = div_err_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = iStart ? PREP : IDLE;
        if (iStart) begin
          word_d = iFunc[0];
          sgn_d = iFunc[1];
          hi_d = iDividend[31:16];
          lo_d = iDividend[15:0];
          dvs_d = iDivisor;
          err_d = 1'b0;
        end
      end
      PREP: begin
        hi_d = mag_hi;
        lo_d = mag_lo;
        dvs_d = dvs_mag;
        qneg_d = dvd_neg ^ dvs_neg;
        rneg_d = dvd_neg;
        err_d = prep_err;
        cnt_d = word_q ? 5'd16 : 5'd8;
        state_d = prep_err ? FIX : ITER;
      end
      ITER: begin
        hi_d = ge ? 16'(trial - {1'b0, dvs_q}) : trial[15:0];
        lo_d = {lo_q[14:0], ge};
        cnt_d = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? FIX : ITER;
      end
      FIX: begin
        div_err_d = fix_err;
        quot_d = fix_err ? quot_q : (word_q ? q_signed : {8'h0, q_signed[7:0]});
        rem_d = fix_err ? rem_q : (word_q ? r_signed : {8'h0, r_signed[7:0]});
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {PREP, ITER, FIX};
    done_d = state_d == DONE;
  end
  // state and output registers, cleared immediately by reset
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      word_q <= 1'b0;
      sgn_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      err_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      sgn_q <= sgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      err_q <= err_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
      div_err_q <= div_err_d;
    end
  end
  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oQuot = quot_q;
  assign oRem = rem_q;
  assign oDivErr = div_err_q;
endmodule

// File: tb/tb_exec_div_seq.sv
// tb_exec_div_seq: scoreboard bench for exec_div_seq; build with DIV_MINNEG_EN to match that DUT configuration
module tb_exec_div_seq;
  logic iClk = 1'b0, iRst_n = 1'b0, iStart = 1'b0;
  logic [3:0] iFunc = '0;
  logic [31:0] iDividend = '0;
  logic [15:0] iDivisor = '0;
  logic oBusy, oDone, oDivErr;
  logic [15:0] oQuot, oRem;
  typedef struct {logic [15:0] q; logic [15:0] r; logic e; int lat;} exp_t;
  typedef struct {logic [3:0] f; logic [31:0] a; logic [15:0] b; logic [15:0] q; logic [15:0] r; logic e; logic keep; int lat;} case_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [15:0] last_q = '0, last_r = '0;

  exec_div_seq dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iFunc(iFunc),
    .iDividend(iDividend), .iDivisor(iDivisor), .oBusy(oBusy), .oDone(oDone),
    .oQuot(oQuot), .oRem(oRem), .oDivErr(oDivErr)
  );

  always #5 iClk = ~iClk;

  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [15:0] b,
                                 input logic [15:0] pq, input logic [15:0] pr);
    exp_t m;
    longint sa, sb_, ma, mb, qq, rr, half;
    int n;
    n = f[0] ? 16 : 8;
    half = longint'(1) << (n - 1);
    if (f[0]) begin
      sa = f[1] ? longint'($signed(a)) : longint'(a);
      sb_ = f[1] ? longint'($signed(b)) : longint'(b);
    end else begin
      sa = f[1] ? longint'($signed(a[15:0])) : longint'(a[15:0]);
      sb_ = f[1] ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end
    ma = sa < 0 ? -sa : sa;
    mb = sb_ < 0 ? -sb_ : sb_;
    m.q = pq; m.r = pr; m.e = 1'b1; m.lat = 2;
    if (mb == 0 || (ma >> n) >= mb) return m;
    qq = sa / sb_;
    rr = sa % sb_;
    m.lat = n + 2;
    if (f[1] && (qq > half - 1 || qq < -half)) return m;
`ifndef DIV_MINNEG_EN
    if (f[1] && qq == -half) return m;
`endif
    m.e = 1'b0;
    m.q = (n == 16) ? qq[15:0] : {8'h0, qq[7:0]};
    m.r = (n == 16) ? rr[15:0] : {8'h0, rr[7:0]};
    return m;
  endfunction

  task automatic drive_start(input logic [3:0] f, input logic [31:0] a, input logic [15:0] b);
    iFunc = f; iDividend = a; iDivisor = b; iStart = 1'b1;
    @(posedge iClk);
    #1 iStart = 1'b0;
    iDividend = $urandom;
    iDivisor = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit seen);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge iClk);
      #1;
      if (oDone) begin lat = i; seen = 1'b1; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", oDone); end
    checks++; if (oDivErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", oDivErr); end
    checks++; if (oQuot !== 16'h0) begin errors++; $display("FAIL reset_quot: got %h want 0000", oQuot); end
    checks++; if (oRem !== 16'h0) begin errors++; $display("FAIL reset_rem: got %h want 0000", oRem); end
    @(negedge iClk) iRst_n = 1'b1;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_plan();
    case_t cs[9];
    exp_t ex, got;
    int lat;
    bit seen;
    cs[0] = '{4'b0001, 32'h00010005, 16'h0003, 16'h5557, 16'h0000, 1'b0, 1'b0, 18};
    cs[1] = '{4'b0010, 32'h0000FF9C, 16'h0007, 16'h00F2, 16'h00FE, 1'b0, 1'b0, 10};
    cs[2] = '{4'b0001, 32'h12345678, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 2};
    cs[3] = '{4'b0001, 32'h00050000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b1, 2};
`ifdef DIV_MINNEG_EN
    cs[4] = '{4'b0011, 32'hFFFF8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 18};
    cs[5] = '{4'b0010, 32'h0000FF80, 16'h0001, 16'h0080, 16'h0000, 1'b0, 1'b0, 10};
`else
    cs[4] = '{4'b0011, 32'hFFFF8000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 18};
    cs[5] = '{4'b0010, 32'h0000FF80, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 10};
`endif
    cs[6] = '{4'b0011, 32'h00008000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 18};
    cs[7] = '{4'b0011, 32'h00000064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 18};
    cs[8] = '{4'b0000, 32'hABCD1234, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b1, 2};
    for (int i = 0; i < 9; i++) begin
      ex.q = cs[i].keep ? last_q : cs[i].q;
      ex.r = cs[i].keep ? last_r : cs[i].r;
      ex.e = cs[i].e;
      ex.lat = cs[i].lat;
      sb.push_back(ex);
      drive_start(cs[i].f, cs[i].a, cs[i].b);
      checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL plan%0d_busy: got %b want 1", i, oBusy); end
      wait_done(lat, seen);
      got = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL plan%0d_timeout: no oDone in 40 cycles, want latency %0d", i, got.lat);
      end else begin
        checks++; if (lat !== got.lat) begin errors++; $display("FAIL plan%0d_latency: got %0d want %0d", i, lat, got.lat); end
        checks++; if (oDivErr !== got.e) begin errors++; $display("FAIL plan%0d_err: got %b want %b", i, oDivErr, got.e); end
        checks++; if (oQuot !== got.q) begin errors++; $display("FAIL plan%0d_quot: got %h want %h", i, oQuot, got.q); end
        checks++; if (oRem !== got.r) begin errors++; $display("FAIL plan%0d_rem: got %h want %h", i, oRem, got.r); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL plan%0d_busy_done: got %b want 0", i, oBusy); end
        @(posedge iClk);
        #1;
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL plan%0d_pulse: got %b want 0", i, oDone); end
      end
      if (!got.e) begin last_q = got.q; last_r = got.r; end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t got;
    int lat;
    bit seen;
    sb.push_back(model(4'b0001, 32'h00010005, 16'h0003, last_q, last_r));
    drive_start(4'b0001, 32'h00010005, 16'h0003);
    iFunc = 4'b0010; iDividend = 32'h0000FF9C; iDivisor = 16'h0007; iStart = 1'b1;
    @(posedge iClk);
    #1;
    @(posedge iClk);
    #1 iStart = 1'b0;
    wait_done(lat, seen);
    got = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL busy_ignore_timeout: no oDone in 40 cycles");
    end else begin
      checks++; if (lat + 2 !== got.lat) begin errors++; $display("FAIL busy_ignore_latency: got %0d want %0d", lat + 2, got.lat); end
      checks++; if ({oDivErr, oQuot, oRem} !== {got.e, got.q, got.r}) begin
        errors++; $display("FAIL busy_ignore_result: got %b/%h/%h want %b/%h/%h", oDivErr, oQuot, oRem, got.e, got.q, got.r);
      end
    end
    if (!got.e) begin last_q = got.q; last_r = got.r; end
    @(posedge iClk);
    #1;
  endtask

  task automatic test_random();
    exp_t got;
    int lat;
    bit seen;
    logic [3:0] f;
    logic [31:0] a;
    logic [15:0] b;
    int sh;
    for (int k = 0; k < 40; k++) begin
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      sh = $urandom_range(0, 3);
      if (sh == 1) a = a >> 12;
      if (sh == 2) a = -(a >> 14);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> 9;
      if ($urandom_range(0, 9) == 0) b = 16'h0;
      sb.push_back(model(f, a, b, last_q, last_r));
      drive_start(f, a, b);
      wait_done(lat, seen);
      got = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rand%0d_timeout: func %b %h/%h no oDone in 40 cycles", k, f, a, b);
      end else begin
        checks++; if (lat !== got.lat) begin errors++; $display("FAIL rand%0d_latency: func %b %h/%h got %0d want %0d", k, f, a, b, lat, got.lat); end
        checks++; if ({oDivErr, oQuot, oRem} !== {got.e, got.q, got.r}) begin
          errors++; $display("FAIL rand%0d_result: func %b %h/%h got %b/%h/%h want %b/%h/%h", k, f, a, b, oDivErr, oQuot, oRem, got.e, got.q, got.r);
        end
      end
      if (!got.e) begin last_q = got.q; last_r = got.r; end
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    drive_start(4'b0001, 32'h00010005, 16'h0003);
    repeat (4) @(posedge iClk);
    #1 iRst_n = 1'b0;
    #1;
    checks++; if ({oBusy, oDone, oDivErr, oQuot, oRem} !== 35'h0) begin
      errors++; $display("FAIL abort_outputs: got busy %b done %b err %b quot %h rem %h want all zero", oBusy, oDone, oDivErr, oQuot, oRem);
    end
    last_q = '0; last_r = '0;
    @(negedge iClk) iRst_n = 1'b1;
    wait_done(lat, seen);
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done: got oDone at cycle %0d want none", lat); end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    int lat;
    bit seen;
    sb.push_back('{16'h5557, 16'h0000, 1'b0, 18});
    drive_start(4'b0001, 32'h00010005, 16'h0003);
    wait_done(lat, seen);
    got = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL b2b_first_timeout: no oDone in 40 cycles");
    end else begin
      checks++; if (lat !== got.lat) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, got.lat); end
      checks++; if ({oDivErr, oQuot, oRem} !== {got.e, got.q, got.r}) begin
        errors++; $display("FAIL b2b_first_result: got %b/%h/%h want %b/%h/%h", oDivErr, oQuot, oRem, got.e, got.q, got.r);
      end
    end
    sb.push_back('{16'hFFF2, 16'hFFFE, 1'b0, 18});
    drive_start(4'b0011, 32'hFFFFFF9C, 16'h0007);
    wait_done(lat, seen);
    got = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL b2b_second_timeout: no oDone in 40 cycles");
    end else begin
      checks++; if (lat !== got.lat) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, got.lat); end
      checks++; if ({oDivErr, oQuot, oRem} !== {got.e, got.q, got.r}) begin
        errors++; $display("FAIL b2b_second_result: got %b/%h/%h want %b/%h/%h", oDivErr, oQuot, oRem, got.e, got.q, got.r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_busy_ignore();
    test_random();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
